// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset PC, fetch FSM encodings and NOP constant for the fetch stage.
package inst_fetch_pkg;

  localparam int INST_BUS_LENGTH = 16;
  localparam int PC_BUS_LENGTH   = 16;

  localparam logic [PC_BUS_LENGTH-1:0]   RESET_PC_VAL = 16'h0000;
  localparam logic [INST_BUS_LENGTH-1:0] NOP_INST     = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if_id_reg.sv
// IF/ID pipeline register: bubble beats load, otherwise holds.
module if_id_reg
  import inst_fetch_pkg::*;
#(
  parameter int INST_WIDTH = INST_BUS_LENGTH,
  parameter int PC_WIDTH   = PC_BUS_LENGTH
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  load_i,
  input  logic                  bubble_i,
  input  logic [INST_WIDTH-1:0] inst_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic                  valid_o
);

  logic [INST_WIDTH-1:0] inst_d, inst_q;
  logic [PC_WIDTH-1:0]   pc_d, pc_q;
  logic                  valid_d, valid_q;

  always_comb begin
    inst_d  = inst_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (bubble_i) begin
      inst_d  = INST_WIDTH'(NOP_INST);
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (load_i) begin
      inst_d  = inst_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      inst_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, fetch FSM with stall buffer and redirect drop, feeding the IF/ID register.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int                  INST_WIDTH = INST_BUS_LENGTH,
  parameter int                  PC_WIDTH   = PC_BUS_LENGTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_PC_VAL)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  redirect_valid_i,
  input  logic [PC_WIDTH-1:0]   redirect_pc_i,
  output logic                  imem_req_o,
  output logic [PC_WIDTH-1:0]   imem_addr_o,
  input  logic                  imem_ack_i,
  input  logic [INST_WIDTH-1:0] imem_data_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [PC_WIDTH-1:0]   pc_o,
  output logic                  inst_valid_o
);

  fetch_state_e          state_d, state_q;
  logic [PC_WIDTH-1:0]   pc_d, pc_q;
  logic [PC_WIDTH-1:0]   drop_addr_d, drop_addr_q;
  logic [INST_WIDTH-1:0] buf_inst_d, buf_inst_q;
  logic [PC_WIDTH-1:0]   buf_pc_d, buf_pc_q;

  logic                  ifid_load;
  logic                  ifid_bubble;
  logic [INST_WIDTH-1:0] ifid_inst;
  logic [PC_WIDTH-1:0]   ifid_pc;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (redirect_valid_i && !imem_ack_i) begin
          state_d = ST_DROP;
        end else if (!redirect_valid_i && imem_ack_i && stall_i) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect_valid_i || !stall_i) begin
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_ack_i) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = '0;
    case (state_q)
      ST_REQ: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_q;
      end
      ST_DROP: begin
        imem_req_o  = 1'b1;
        imem_addr_o = drop_addr_q;
      end
      default: ;
    endcase
  end

  // A redirect always wins the PC; the in-flight word is either discarded now or drained in DROP.
  always_comb begin
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    ifid_load   = 1'b0;
    ifid_inst   = imem_data_i;
    ifid_pc     = pc_q;
    case (state_q)
      ST_REQ: begin
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
          if (!imem_ack_i) begin
            drop_addr_d = pc_q;
          end
        end else if (imem_ack_i) begin
          pc_d = pc_q + PC_WIDTH'(1);
          if (stall_i) begin
            buf_inst_d = imem_data_i;
            buf_pc_d   = pc_q;
          end else begin
            ifid_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        ifid_inst = buf_inst_q;
        ifid_pc   = buf_pc_q;
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
        end else if (!stall_i) begin
          ifid_load = 1'b1;
        end
      end
      ST_DROP: begin
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
        end
      end
      default: ;
    endcase
  end

  // Flush forces a bubble even under stall; otherwise an unstalled cycle without a load is a bubble.
  assign ifid_bubble = flush_i || (!stall_i && !ifid_load);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      buf_inst_q  <= '0;
      buf_pc_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
    end
  end

  if_id_reg #(
    .INST_WIDTH (INST_WIDTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_if_id_reg (
    .clk_i    (clk_i),
    .rstn_i   (rstn_i),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .inst_i   (ifid_inst),
    .pc_i     (ifid_pc),
    .inst_o   (inst_o),
    .pc_o     (pc_o),
    .valid_o  (inst_valid_o)
  );

endmodule
